// File: rtl/arb8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb8_pkg
// Description : Shared types, sizes and scan helper for the 8-way RR arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Lowest set bit wins; the caller rotates the vector so bit 0 is the
    // highest-priority position.
    function automatic logic [SEL_W-1:0] find_first(input logic [N_REQ-1:0] vec);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux8.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux8
// Description : Combinational 8:1 data select by sel, forced to 0 when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] din,
    input  logic [SEL_W-1:0] sel,
    input  logic             out_valid,
    output logic             out_data
);

    logic [N_REQ-1:0] w_hit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hit
        assign w_hit[gi] = din[gi] & (sel == SEL_W'(gi));
    end

    assign out_data = out_valid & (|w_hit);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-requester round-robin arbiter with burst limit and release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import arb8_pkg::*;
#(
    parameter int MAX_BURST = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic             out_data,
    output logic             busy
);

    arb_state_e       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_off;
    logic [SEL_W-1:0]   w_pick;
    logic               w_granted;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_burst_done;
    logic               w_exit;

    // Rotate so position ptr lands at bit 0, pick first, then add ptr back.
    assign w_dbl  = {req, req};
    assign w_rot  = w_dbl[r_ptr +: N_REQ];
    assign w_off  = find_first(w_rot);
    assign w_pick = r_ptr + w_off;

    assign w_granted    = (r_state == GRANT);
    assign w_xfer       = w_granted & out_ready;
    assign w_cnt_inc    = r_count + 4'd1;
    assign w_burst_done = w_xfer & (w_cnt_inc == CNT_W'(MAX_BURST));
    assign w_exit       = w_granted & (~req[r_sel] | w_burst_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_sel   <= w_pick;
                        r_count <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_exit) begin
                        r_ptr   <= r_sel + 3'd1;
                        r_count <= '0;
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        r_count <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = w_granted ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_sel) : '0;
    assign sel       = r_sel;
    assign out_valid = w_granted;
    assign busy      = w_granted;

    rr_mux8 u_mux (
        .din       (din),
        .sel       (r_sel),
        .out_valid (w_granted),
        .out_data  (out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Self-checking bench for rr_arbiter8 against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    localparam int MAX_B = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic       out_ready;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_data;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the channel, how many transfers so far,
    // and where the next search starts.
    bit m_busy;
    int m_sel;
    int m_ptr;
    int m_cnt;

    rr_arbiter8 #(.MAX_BURST(MAX_B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] exp_vec();
        logic [7:0] g;
        logic       od;
        g  = m_busy ? 8'(1 << m_sel) : 8'h00;
        od = m_busy ? din[m_sel] : 1'b0;
        return {g, 3'(m_sel), m_busy, od, m_busy};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {gnt, sel, out_valid, out_data, busy};
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 8'h00; din = 8'h00; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input logic [7:0] r, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        req = r; din = d; out_ready = rdy;
        #1;
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic advance();
        int c;
        @(posedge clk);
        if (m_busy) begin
            c = m_cnt + (out_ready ? 1 : 0);
            if (!req[m_sel] || c == MAX_B) begin
                m_busy = 0;
                m_ptr  = (m_sel + 1) % 8;
                m_cnt  = 0;
            end else begin
                m_cnt = c;
            end
        end else if (req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (req[(m_ptr + k) % 8]) begin
                    m_sel = (m_ptr + k) % 8;
                    break;
                end
            end
            m_busy = 1;
            m_cnt  = 0;
        end
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if (obs_vec() !== 14'h0) begin
            n_err++;
            $display("FAIL reset_initial: got %b want %b", obs_vec(), 14'h0);
        end
        @(negedge clk);
        req = 8'hFF; out_ready = 1'b1; din = 8'hFF;
        @(posedge clk);
        #1;
        n_vec++;
        if (obs_vec() !== 14'h0) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", obs_vec(), 14'h0);
        end
    endtask

    task automatic test_single();
        logic [7:0] hist [12];
        int run;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(8'h01, 8'($urandom), 1'b1);
            hist[i] = gnt;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            advance();
        end
        run = 0;
        for (int i = 1; i < 12 && hist[i] == 8'h01; i++) run++;
        n_vec++;
        if (run !== MAX_B || hist[5] !== 8'h00 || hist[6] !== 8'h01) begin
            n_err++;
            $display("FAIL single_burst: run=%0d bubble=%h regrant=%h want run=%0d bubble=00 regrant=01",
                     run, hist[5], hist[6], MAX_B);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] hist [16];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(8'h81, 8'($urandom), 1'b1);
            hist[i] = gnt;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            advance();
        end
        n_vec++;
        if (hist[1] !== 8'h01 || hist[5] !== 8'h00 || hist[6] !== 8'h80 ||
            hist[10] !== 8'h00 || hist[11] !== 8'h01) begin
            n_err++;
            $display("FAIL wrap_order: got %h %h %h %h %h want 01 00 80 00 01",
                     hist[1], hist[5], hist[6], hist[10], hist[11]);
        end
    endtask

    task automatic test_stall();
        int xfers, held;
        xfers = 0; held = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(8'h08, 8'($urandom), (i >= 11));
            if (gnt == 8'h08) held++;
            if (gnt == 8'h08 && out_valid && out_ready) xfers++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stall cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            advance();
        end
        n_vec++;
        if (xfers !== MAX_B || held !== 14) begin
            n_err++;
            $display("FAIL stall_count: xfers=%0d held=%0d want xfers=%0d held=14", xfers, held, MAX_B);
        end
    endtask

    task automatic test_release();
        logic [7:0] rs [6];
        logic [7:0] hist [6];
        rs = '{8'h20, 8'h20, 8'h20, 8'h01, 8'h21, 8'h21};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(rs[i], 8'($urandom), 1'b1);
            hist[i] = gnt;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL release cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            advance();
        end
        n_vec++;
        if (hist[3] !== 8'h20 || hist[4] !== 8'h00 || hist[5] !== 8'h01) begin
            n_err++;
            $display("FAIL release_order: got %h %h %h want 20 00 01", hist[3], hist[4], hist[5]);
        end
    endtask

    task automatic test_data();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            apply(8'h04, d, 1'($urandom));
            n_vec++;
            if (out_data !== (gnt == 8'h04 ? d[2] : 1'b0) || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL data cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(8'hFF, 8'($urandom), 1'b1);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL areset_pre cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            advance();
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs_vec() !== 14'h0) begin
            n_err++;
            $display("FAIL areset_drop: got %b want %b", obs_vec(), 14'h0);
        end
        req = 8'h00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(8'hFF, 8'($urandom), 1'b1);
            n_vec++;
            if (obs_vec() !== exp_vec() || (i == 1 && gnt !== 8'h01)) begin
                n_err++;
                $display("FAIL areset_post cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        r = 8'h00;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
            apply(r, 8'($urandom), ($urandom_range(0, 3) != 0));
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d: req=%h got %b want %b", i, r, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 8'h00; din = 8'h00; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_release();
        test_data();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL be the maximum number of accepted transfers per grant (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 req  input  8  SHALL carry requests; req[i] high means requester i wants the shared channel.
REQ-005 din  input  8  SHALL carry data; din[i] is requester i's serial data bit.
REQ-006 out_ready  input  1  SHALL be the downstream acceptance strobe.
REQ-007 gnt  output  8  SHALL be the one-hot grant to the requesters.
REQ-008 sel  output  3  SHALL be the binary index of the granted requester, the select code for the 8:1 mux.
REQ-009 out_valid  output  1  SHALL flag valid data on out_data.
REQ-010 out_data  output  1  SHALL be din[sel] while out_valid is high, else 0.
REQ-011 busy  output  1  SHALL be high whenever the FSM is in GRANT.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-013 In IDLE with req==0, the FSM SHALL stay in IDLE, with gnt=0 and out_valid=0.
REQ-014 In IDLE with req!=0, the next edge SHALL load sel with the first set index scanning ptr, ptr+1, ..., ptr+7 mod 8, clear burst count, and enter GRANT.
REQ-015 In GRANT, gnt SHALL equal 1<<sel, out_valid SHALL be 1, and out_data SHALL be combinationally din[sel], so data latency is zero.
REQ-016 A transfer SHALL occur on each edge where out_valid && out_ready; each transfer increments the 4-bit burst count.
REQ-017 GRANT SHALL exit to IDLE on the edge where req[sel]==0, the release condition, regardless of out_ready; a transfer coincident with release still counts as accepted.
REQ-018 GRANT SHALL exit to IDLE on the edge where a transfer brings the burst count to MAX_BURST.
REQ-019 On every GRANT exit, ptr SHALL load (sel+1) mod 8, wrapping 7->0, and count SHALL clear.
REQ-020 While the FSM is in GRANT, sel SHALL NOT change, and request changes from other requesters SHALL NOT affect sel.
REQ-021 Every GRANT exit SHALL be followed by one IDLE cycle before any new grant, giving a deterministic one-cycle bubble.
REQ-022 With out_ready low, GRANT SHALL hold indefinitely with count frozen, unless release occurs.
REQ-023 sel SHALL hold its last value in IDLE; only gnt and out_valid are forced to 0.

Reset
REQ-024 On rst_n low, the block SHALL asynchronously force state=IDLE, sel=0, ptr=0, count=0, gnt=0, out_valid=0, out_data=0, busy=0.
REQ-025 A reset asserted mid-burst SHALL abort the grant immediately, with no transfer counted on that edge.
REQ-026 After reset deassertion, arbitration SHALL start from ptr=0.

Structure
REQ-027 Package arb8_pkg SHALL hold the state enum (IDLE, GRANT), N_REQ=8, SEL_W=3 and CNT_W=4.
REQ-028 The data path SHALL be one sub-module, rr_mux8, a purely combinational 8:1 select of din by sel, gated to 0 when out_valid is low.
REQ-029 The priority scan (REQ-014) SHALL be implemented as rotate-by-ptr, find-first, un-rotate, with no ordering loop that depends on ptr as a loop bound.

Verification
REQ-030 After reset with req=8'h01, out_ready=1 and MAX_BURST=4, gnt SHALL be 8'h01 for exactly 4 cycles, followed by 1 IDLE cycle and a regrant to 0.
REQ-031 With req=8'h81 held, out_ready=1 and ptr=0, grants SHALL alternate 0 and 7, each 4 transfers with 1-cycle bubbles, exercising wrap 7->0.
REQ-032 With sel=3 granted, out_ready=0 for 10 cycles and then 1, gnt SHALL stay 8'h08 throughout, and exactly 4 transfers SHALL occur after out_ready rises.
REQ-033 With sel=5 granted and req[5] dropped after 2 transfers, the FSM SHALL return to IDLE the next edge; with req=8'h21 the next grant SHALL be 0 (ptr=6 scans 6,7,0).
REQ-034 With din toggling while sel=2 is granted, out_data SHALL equal din[2] each cycle and SHALL be 0 during the IDLE bubble.
REQ-035 With rst_n pulsed low asynchronously mid-burst, gnt, out_valid and busy SHALL drop before the next edge; after release with req=8'hFF, the first grant SHALL be 0.
